// File: rtl/memristor_mul_pkg.sv
// Shared constants and types for the memristor multiplier AXI4-Lite sequencer.
package memristor_mul_pkg;

    localparam logic [31:0] REG_CTRL   = 32'h0000_0000;
    localparam logic [31:0] REG_STAT   = 32'h0000_0004;
    localparam logic [31:0] REG_MUL_A  = 32'h0000_0008;
    localparam logic [31:0] REG_MUL_B  = 32'h0000_000C;
    localparam logic [31:0] REG_RESULT = 32'h0000_0010;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        WR_A,
        WR_B,
        WR_GO,
        RD_STAT,
        GAP,
        RD_RES,
        OUT
    } mul_state_t;

    function automatic logic [31:0] sext4(input logic [3:0] v);
        return {{28{v[3]}}, v};
    endfunction

endpackage

// File: rtl/axil_single_xfer.sv
// One-word AXI4-Lite master engine: a start pulse launches a single read or write,
// done pulses in the cycle of the B/R handshake, and err flags a non-OKAY response.
module axil_single_xfer
    import memristor_mul_pkg::*;
(
    input  logic        ACLK,
    input  logic        ARESETn,

    input  logic        start,
    input  logic        is_read,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,

    output logic [31:0] M_AWADDR,
    output logic [2:0]  M_AWPROT,
    output logic        M_AWVALID,
    input  logic        M_AWREADY,
    output logic [31:0] M_WDATA,
    output logic [3:0]  M_WSTRB,
    output logic        M_WVALID,
    input  logic        M_WREADY,
    input  logic [1:0]  M_BRESP,
    input  logic        M_BVALID,
    output logic        M_BREADY,
    output logic [31:0] M_ARADDR,
    output logic [2:0]  M_ARPROT,
    output logic        M_ARVALID,
    input  logic        M_ARREADY,
    input  logic [31:0] M_RDATA,
    input  logic [1:0]  M_RRESP,
    input  logic        M_RVALID,
    output logic        M_RREADY
);

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_pending, w_pending;

    assign aw_hs = M_AWVALID & M_AWREADY;
    assign w_hs  = M_WVALID  & M_WREADY;
    assign b_hs  = M_BVALID  & M_BREADY;
    assign ar_hs = M_ARVALID & M_ARREADY;
    assign r_hs  = M_RVALID  & M_RREADY;

    assign aw_pending = M_AWVALID & ~M_AWREADY;
    assign w_pending  = M_WVALID  & ~M_WREADY;

    assign done  = b_hs | r_hs;
    assign err   = (b_hs && (M_BRESP != RESP_OKAY)) || (r_hs && (M_RRESP != RESP_OKAY));
    assign rdata = M_RDATA;

    assign M_AWPROT = 3'b000;
    assign M_ARPROT = 3'b000;
    assign M_WSTRB  = M_WVALID ? 4'hF : 4'h0;

    // A start arriving in the same cycle as the previous done chains transactions back to back.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            M_AWADDR  <= '0;
            M_AWVALID <= 1'b0;
            M_WDATA   <= '0;
            M_WVALID  <= 1'b0;
            M_BREADY  <= 1'b0;
            M_ARADDR  <= '0;
            M_ARVALID <= 1'b0;
            M_RREADY  <= 1'b0;
        end else begin
            if (aw_hs) M_AWVALID <= 1'b0;
            if (w_hs)  M_WVALID  <= 1'b0;
            if ((M_AWVALID || M_WVALID) && !aw_pending && !w_pending) M_BREADY <= 1'b1;
            if (b_hs)  M_BREADY  <= 1'b0;
            if (ar_hs) begin
                M_ARVALID <= 1'b0;
                M_RREADY  <= 1'b1;
            end
            if (r_hs)  M_RREADY  <= 1'b0;
            if (start) begin
                if (is_read) begin
                    M_ARVALID <= 1'b1;
                    M_ARADDR  <= addr;
                end else begin
                    M_AWVALID <= 1'b1;
                    M_WVALID  <= 1'b1;
                    M_AWADDR  <= addr;
                    M_WDATA   <= wdata;
                end
            end
        end
    end

endmodule

// File: rtl/memristor_mul_axil_master.sv
// Sequencer that runs a full multiply on the memristor multiplier slave per operand pair.
// Optional build macro: MEMRISTOR_MUL_POLL_TIMEOUT_EN adds a status-poll timeout.
module memristor_mul_axil_master
    import memristor_mul_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE     = 32'h0000_0000,
    parameter int          POLL_GAP      = 2,
    parameter int          TIMEOUT_POLLS = 64
) (
    input  logic        ACLK,
    input  logic        ARESETn,

    input  logic        s_valid,
    output logic        s_ready,
    input  logic [3:0]  s_a,
    input  logic [3:0]  s_b,

    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_product,
    output logic        m_err,

    output logic        busy,

    output logic [31:0] M_AWADDR,
    output logic [2:0]  M_AWPROT,
    output logic        M_AWVALID,
    input  logic        M_AWREADY,
    output logic [31:0] M_WDATA,
    output logic [3:0]  M_WSTRB,
    output logic        M_WVALID,
    input  logic        M_WREADY,
    input  logic [1:0]  M_BRESP,
    input  logic        M_BVALID,
    output logic        M_BREADY,
    output logic [31:0] M_ARADDR,
    output logic [2:0]  M_ARPROT,
    output logic        M_ARVALID,
    input  logic        M_ARREADY,
    input  logic [31:0] M_RDATA,
    input  logic [1:0]  M_RRESP,
    input  logic        M_RVALID,
    output logic        M_RREADY
);

    mul_state_t  state, state_nxt;
    logic [3:0]  op_b;
    logic        rst_done;
    logic [15:0] gap_cnt;

    logic        xfer_start, xfer_read, xfer_done, xfer_err;
    logic [31:0] xfer_addr, xfer_wdata, xfer_rdata;
    logic        to_out, out_err;
    logic [7:0]  out_prod;

`ifdef MEMRISTOR_MUL_POLL_TIMEOUT_EN
    logic [15:0] poll_cnt;
    logic        timeout_hit;
    assign timeout_hit = (int'(poll_cnt) + 1) >= TIMEOUT_POLLS;
`endif

    assign s_ready = rst_done && (state == IDLE);
    assign m_valid = (state == OUT);
    assign busy    = (state != IDLE);

    axil_single_xfer u_xfer (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .start     (xfer_start),
        .is_read   (xfer_read),
        .addr      (xfer_addr),
        .wdata     (xfer_wdata),
        .done      (xfer_done),
        .err       (xfer_err),
        .rdata     (xfer_rdata),
        .M_AWADDR  (M_AWADDR),
        .M_AWPROT  (M_AWPROT),
        .M_AWVALID (M_AWVALID),
        .M_AWREADY (M_AWREADY),
        .M_WDATA   (M_WDATA),
        .M_WSTRB   (M_WSTRB),
        .M_WVALID  (M_WVALID),
        .M_WREADY  (M_WREADY),
        .M_BRESP   (M_BRESP),
        .M_BVALID  (M_BVALID),
        .M_BREADY  (M_BREADY),
        .M_ARADDR  (M_ARADDR),
        .M_ARPROT  (M_ARPROT),
        .M_ARVALID (M_ARVALID),
        .M_ARREADY (M_ARREADY),
        .M_RDATA   (M_RDATA),
        .M_RRESP   (M_RRESP),
        .M_RVALID  (M_RVALID),
        .M_RREADY  (M_RREADY)
    );

    // Each state launches its successor's transaction on the completing handshake.
    always_comb begin
        state_nxt  = state;
        xfer_start = 1'b0;
        xfer_read  = 1'b0;
        xfer_addr  = ADDR_BASE;
        xfer_wdata = '0;
        to_out     = 1'b0;
        out_err    = 1'b0;
        out_prod   = '0;

        unique case (state)
            IDLE: begin
                if (s_valid && s_ready) begin
                    state_nxt  = WR_A;
                    xfer_start = 1'b1;
                    xfer_addr  = ADDR_BASE + REG_MUL_A;
                    xfer_wdata = sext4(s_a);
                end
            end
            WR_A: begin
                if (xfer_done) begin
                    if (xfer_err) begin
                        to_out  = 1'b1;
                        out_err = 1'b1;
                    end else begin
                        state_nxt  = WR_B;
                        xfer_start = 1'b1;
                        xfer_addr  = ADDR_BASE + REG_MUL_B;
                        xfer_wdata = sext4(op_b);
                    end
                end
            end
            WR_B: begin
                if (xfer_done) begin
                    if (xfer_err) begin
                        to_out  = 1'b1;
                        out_err = 1'b1;
                    end else begin
                        state_nxt  = WR_GO;
                        xfer_start = 1'b1;
                        xfer_addr  = ADDR_BASE + REG_CTRL;
                        xfer_wdata = 32'h0000_0001;
                    end
                end
            end
            WR_GO: begin
                if (xfer_done) begin
                    if (xfer_err) begin
                        to_out  = 1'b1;
                        out_err = 1'b1;
                    end else begin
                        state_nxt  = RD_STAT;
                        xfer_start = 1'b1;
                        xfer_read  = 1'b1;
                        xfer_addr  = ADDR_BASE + REG_STAT;
                    end
                end
            end
            RD_STAT: begin
                if (xfer_done) begin
                    if (xfer_err) begin
                        to_out  = 1'b1;
                        out_err = 1'b1;
                    end else if (xfer_rdata[0]) begin
                        state_nxt  = RD_RES;
                        xfer_start = 1'b1;
                        xfer_read  = 1'b1;
                        xfer_addr  = ADDR_BASE + REG_RESULT;
                    end else begin
`ifdef MEMRISTOR_MUL_POLL_TIMEOUT_EN
                        if (timeout_hit) begin
                            to_out  = 1'b1;
                            out_err = 1'b1;
                        end else
`endif
                        if (POLL_GAP == 0) begin
                            xfer_start = 1'b1;
                            xfer_read  = 1'b1;
                            xfer_addr  = ADDR_BASE + REG_STAT;
                        end else begin
                            state_nxt = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if ((int'(gap_cnt) + 1) >= POLL_GAP) begin
                    state_nxt  = RD_STAT;
                    xfer_start = 1'b1;
                    xfer_read  = 1'b1;
                    xfer_addr  = ADDR_BASE + REG_STAT;
                end
            end
            RD_RES: begin
                if (xfer_done) begin
                    to_out = 1'b1;
                    if (xfer_err) out_err  = 1'b1;
                    else          out_prod = xfer_rdata[7:0];
                end
            end
            OUT: begin
                if (m_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (to_out) state_nxt = OUT;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= IDLE;
            rst_done  <= 1'b0;
            op_b      <= '0;
            gap_cnt   <= '0;
            m_product <= '0;
            m_err     <= 1'b0;
        end else begin
            state    <= state_nxt;
            rst_done <= 1'b1;
            if (state == IDLE && s_valid && s_ready) op_b <= s_b;
            gap_cnt <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;
            if (to_out) begin
                m_product <= out_prod;
                m_err     <= out_err;
            end
        end
    end

`ifdef MEMRISTOR_MUL_POLL_TIMEOUT_EN
    // Counts status reads that came back without done during one operation.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            poll_cnt <= '0;
        end else if (state == IDLE) begin
            poll_cnt <= '0;
        end else if (state == RD_STAT && xfer_done && !xfer_err && !xfer_rdata[0]) begin
            poll_cnt <= poll_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_memristor_mul_axil_master.sv
// Self-checking bench: behavioural AXI4-Lite multiplier slave plus an arithmetic reference
// for products, register writes, poll counts and latency.
module tb_memristor_mul_axil_master;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          GAP  = 2;

    logic        ACLK;
    logic        ARESETn;
    logic        s_valid, s_ready;
    logic [3:0]  s_a, s_b;
    logic        m_valid, m_ready, m_err, busy;
    logic [7:0]  m_product;
    logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
    logic [2:0]  M_AWPROT, M_ARPROT;
    logic [3:0]  M_WSTRB;
    logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
    logic        M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
    logic [1:0]  M_BRESP, M_RRESP;

    int n_cmp = 0;
    int n_mis = 0;

    int          aw_delay   = 0;
    int          done_after = 1;
    bit          err_en     = 0;
    logic [31:0] err_addr   = '0;
    int          aw_wait;
    int          cycle = 0;
    bit          aw_have, w_have;
    logic [31:0] aw_l, w_l, reg_a, reg_b;
    int          polls;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          stat_cyc_q[$];

    memristor_mul_axil_master #(
        .ADDR_BASE     (BASE),
        .POLL_GAP      (GAP),
        .TIMEOUT_POLLS (64)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_a       (s_a),
        .s_b       (s_b),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_product (m_product),
        .m_err     (m_err),
        .busy      (busy),
        .M_AWADDR  (M_AWADDR),
        .M_AWPROT  (M_AWPROT),
        .M_AWVALID (M_AWVALID),
        .M_AWREADY (M_AWREADY),
        .M_WDATA   (M_WDATA),
        .M_WSTRB   (M_WSTRB),
        .M_WVALID  (M_WVALID),
        .M_WREADY  (M_WREADY),
        .M_BRESP   (M_BRESP),
        .M_BVALID  (M_BVALID),
        .M_BREADY  (M_BREADY),
        .M_ARADDR  (M_ARADDR),
        .M_ARPROT  (M_ARPROT),
        .M_ARVALID (M_ARVALID),
        .M_ARREADY (M_ARREADY),
        .M_RDATA   (M_RDATA),
        .M_RRESP   (M_RRESP),
        .M_RVALID  (M_RVALID),
        .M_RREADY  (M_RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cycle <= cycle + 1;

    assign M_AWREADY = M_AWVALID && (aw_wait >= aw_delay);
    assign M_WREADY  = M_WVALID;
    assign M_ARREADY = M_ARVALID;

    // Slave model: register file, done after done_after polls, optional error response.
    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_wait  <= 0;
            aw_have  = 1'b0;
            w_have   = 1'b0;
            polls    = 0;
            M_BVALID <= 1'b0;
            M_BRESP  <= 2'b00;
            M_RVALID <= 1'b0;
            M_RRESP  <= 2'b00;
            M_RDATA  <= '0;
        end else begin
            if (M_BVALID && M_BREADY) M_BVALID <= 1'b0;
            if (M_RVALID && M_RREADY) M_RVALID <= 1'b0;
            if (M_AWVALID && M_AWREADY) begin
                aw_have = 1'b1;
                aw_l    = M_AWADDR;
                aw_wait <= 0;
            end else if (M_AWVALID) begin
                aw_wait <= aw_wait + 1;
            end
            if (M_WVALID && M_WREADY) begin
                w_have = 1'b1;
                w_l    = M_WDATA;
            end
            if (aw_have && w_have) begin
                aw_have = 1'b0;
                w_have  = 1'b0;
                wr_addr_q.push_back(aw_l);
                wr_data_q.push_back(w_l);
                M_BVALID <= 1'b1;
                M_BRESP  <= (err_en && aw_l == err_addr) ? 2'b10 : 2'b00;
                if (aw_l == BASE + 32'h8) reg_a = w_l;
                if (aw_l == BASE + 32'hC) reg_b = w_l;
                if (aw_l == BASE && w_l == 32'h1) polls = 0;
            end
            if (M_ARVALID && M_ARREADY) begin
                M_RVALID <= 1'b1;
                M_RRESP  <= 2'b00;
                if (M_ARADDR == BASE + 32'h4) begin
                    polls++;
                    stat_cyc_q.push_back(cycle);
                    M_RDATA <= (polls >= done_after) ? 32'h1 : 32'h0;
                end else if (M_ARADDR == BASE + 32'h10) begin
                    M_RDATA <= {24'h0, 8'(int'($signed(reg_a[3:0])) * int'($signed(reg_b[3:0])))};
                end else begin
                    M_RDATA <= '0;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends one pair and returns the cycles from the s handshake edge until m_valid.
    task automatic applyStimulus(input int a, input int b, output int lat);
        int guard;
        wr_addr_q.delete();
        wr_data_q.delete();
        stat_cyc_q.delete();
        guard = 0;
        while (!s_ready && guard < 50) begin
            @(negedge ACLK);
            guard++;
        end
        checkOutput("s_ready_wait", {31'b0, s_ready}, 32'h1);
        s_a     = 4'(a);
        s_b     = 4'(b);
        s_valid = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        s_valid = 1'b0;
        lat = 0;
        while (!m_valid && lat < 2000) begin
            @(posedge ACLK);
            lat++;
            @(negedge ACLK);
        end
        checkOutput("m_valid_wait", {31'b0, m_valid}, 32'h1);
    endtask

    task automatic finishOp();
        m_ready = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        m_ready = 1'b0;
    endtask

    task automatic checkWrites(input string tag, input int a, input int b, input int n);
        logic [31:0] exp_addr[3];
        logic [31:0] exp_data[3];
        exp_addr = '{BASE + 32'h8, BASE + 32'hC, BASE};
        exp_data = '{32'(a), 32'(b), 32'h1};
        checkOutput({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            checkOutput({tag, "_waddr"}, wr_addr_q[i], exp_addr[i]);
            checkOutput({tag, "_wdata"}, wr_data_q[i], exp_data[i]);
        end
    endtask

    task automatic runOp(input string tag, input int a, input int b, input int d, input int polls_n);
        int lat;
        aw_delay   = d;
        done_after = polls_n;
        applyStimulus(a, b, lat);
        checkOutput({tag, "_product"}, {24'h0, m_product}, {24'h0, 8'(a * b)});
        checkOutput({tag, "_err"}, {31'b0, m_err}, 32'h0);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(10 + 3 * d + (polls_n - 1) * (2 + GAP)));
        checkOutput({tag, "_npolls"}, 32'(stat_cyc_q.size()), 32'(polls_n));
        checkWrites(tag, a, b, 3);
        finishOp();
    endtask

    initial begin
        int lat;
        int ra, rb, rd, rp;
        ARESETn = 1'b0;
        s_valid = 1'b0;
        s_a     = '0;
        s_b     = '0;
        m_ready = 1'b0;
        repeat (3) @(negedge ACLK);

        checkOutput("rst_s_ready", {31'b0, s_ready}, 32'h0);
        checkOutput("rst_valids", {27'b0, M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY}, 32'h0);
        checkOutput("rst_m_valid", {31'b0, m_valid}, 32'h0);
        checkOutput("rst_busy", {31'b0, busy}, 32'h0);
        checkOutput("rst_product", {23'b0, m_err, m_product}, 32'h0);
        checkOutput("rst_awaddr", M_AWADDR, 32'h0);
        ARESETn = 1'b1;
        @(negedge ACLK);
        checkOutput("s_ready_after_rst", {31'b0, s_ready}, 32'h1);

        $display("[TB] directed products");
        runOp("a3b7", 3, 7, 0, 1);
        runOp("am3b5", -3, 5, 0, 1);
        runOp("am8bm8", -8, -8, 0, 1);
        runOp("am8b7", -8, 7, 0, 1);

        $display("[TB] slow AWREADY, done on fifth poll");
        runOp("slow", -7, 6, 3, 5);
        for (int i = 1; i < stat_cyc_q.size(); i++)
            checkOutput("poll_spacing", 32'(stat_cyc_q[i] - stat_cyc_q[i-1] >= 2 + GAP), 32'h1);

        $display("[TB] error response on multiplicand write");
        err_en   = 1'b1;
        err_addr = BASE + 32'hC;
        aw_delay = 0;
        done_after = 1;
        applyStimulus(5, 3, lat);
        checkOutput("berr_err", {31'b0, m_err}, 32'h1);
        checkOutput("berr_product", {24'h0, m_product}, 32'h0);
        checkOutput("berr_npolls", 32'(stat_cyc_q.size()), 32'h0);
        checkWrites("berr", 5, 3, 2);
        finishOp();
        err_en = 1'b0;

        $display("[TB] back-pressure on result stream");
        applyStimulus(4, -2, lat);
        s_a     = 4'd1;
        s_b     = 4'd1;
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("hold_product", {24'h0, m_product}, 32'h000000F8);
            checkOutput("hold_m_valid", {31'b0, m_valid}, 32'h1);
            checkOutput("hold_s_ready", {31'b0, s_ready}, 32'h0);
            @(negedge ACLK);
        end
        m_ready = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        m_ready = 1'b0;
        checkOutput("post_hs_m_valid", {31'b0, m_valid}, 32'h0);
        checkOutput("post_hs_s_ready", {31'b0, s_ready}, 32'h1);
        s_valid = 1'b0;
        @(negedge ACLK);

        $display("[TB] reset during status polling");
        done_after = 1000;
        s_a     = 4'd1;
        s_b     = 4'd1;
        s_valid = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        s_valid = 1'b0;
        lat = 0;
        while (!(M_ARVALID && M_ARADDR == BASE + 32'h4) && lat < 100) begin
            @(negedge ACLK);
            lat++;
        end
        checkOutput("reach_rd_stat", {31'b0, M_ARVALID}, 32'h1);
        #2;
        ARESETn = 1'b0;
        #1;
        checkOutput("midrst_valids", {27'b0, M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY}, 32'h0);
        checkOutput("midrst_flags", {29'b0, s_ready, m_valid, busy}, 32'h0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        runOp("after_rst", 2, 3, 0, 1);

        $display("[TB] randomized operand pairs");
        for (int i = 0; i < 12; i++) begin
            ra = int'($urandom_range(0, 15)) - 8;
            rb = int'($urandom_range(0, 15)) - 8;
            rd = int'($urandom_range(0, 2));
            rp = int'($urandom_range(1, 3));
            runOp("rand", ra, rb, rd, rp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/memristor_mul_axil_master.md
# memristor_mul_axil_master

Upstream sequencer for the 4-bit memristor multiplier AXI4-Lite slave. Accepts signed 4-bit operand pairs on a valid/ready stream and runs the full register protocol over an AXI4-Lite master port: write operands, write start, poll status, read result. Returns the signed 8-bit product on an output stream. It lets datapath logic use the multiplier without a CPU.

## Interface
- ADDR_BASE, 32'h0000_0000: base address of the multiplier slave; register offsets are added to it.
- POLL_GAP, 2: idle cycles between consecutive status reads (0 allowed).
- TIMEOUT_POLLS, 64: status reads before abort; used only with the timeout macro.
- ACLK in 1: single clock.
- ARESETn in 1: asynchronous active-low reset.
- s_valid in 1, s_ready out 1, s_a in 4, s_b in 4: operand stream; a is the multiplier and b is the multiplicand, both two's complement.
- m_valid out 1, m_ready in 1, m_product out 8, m_err out 1: result stream; m_product is signed.
- busy out 1: high in any state except IDLE.
- M_AWADDR out 32, M_AWPROT out 3, M_AWVALID out 1, M_AWREADY in 1: write-address channel.
- M_WDATA out 32, M_WSTRB out 4, M_WVALID out 1, M_WREADY in 1: write-data channel.
- M_BRESP in 2, M_BVALID in 1, M_BREADY out 1: write-response channel.
- M_ARADDR out 32, M_ARPROT out 3, M_ARVALID out 1, M_ARREADY in 1: read-address channel.
- M_RDATA in 32, M_RRESP in 2, M_RVALID in 1, M_RREADY out 1: read-data channel.

## Operation
- Slave register map, as offsets from ADDR_BASE:
  - 0x00: control; writing 1 starts a multiply.
  - 0x04: status; bit0 is done.
  - 0x08: multiplier.
  - 0x0C: multiplicand.
  - 0x10: result, in bits [7:0].
- FSM states: IDLE → WR_A → WR_B → WR_GO → RD_STAT ⇄ GAP → RD_RES → OUT → IDLE.
- IDLE:
  - s_ready is 1 only in IDLE.
  - An s handshake latches s_a and s_b.
- WR_A writes the multiplier to 0x08; WR_B writes the multiplicand to 0x0C; WR_GO writes 32'h1 to 0x00.
- Operand sign extension: the 4-bit operand is sign-extended to 32 bits before writing (-3 → 32'hFFFF_FFFD).
- Write transaction:
  - AWVALID and WVALID rise in the same cycle.
  - Each valid drops independently after its own handshake.
  - BREADY goes high once both handshakes are complete and drops after the BVALID handshake.
  - M_WSTRB = 4'hF while WVALID is high. AWPROT and ARPROT are 0.
- Read transaction:
  - ARVALID is held until the ARREADY handshake.
  - RREADY is high from the AR handshake until the RVALID handshake.
- Polling:
  - Polling starts only after the B response of WR_GO, so a stale done flag is never sampled before start.
  - RD_STAT goes to RD_RES if RDATA[0] = 1, otherwise to GAP.
  - GAP waits POLL_GAP cycles, then returns to RD_STAT.
- RD_RES latches m_product = RDATA[7:0].
- OUT holds m_valid, m_product and m_err stable until m_ready; it returns to IDLE on the handshake.
- Error handling:
  - Any BRESP or RRESP ≠ 2'b00 aborts immediately to OUT with m_err = 1 and m_product = 0.
  - Remaining writes are not issued.
- Arithmetic: the full range fits in the result width (-8·-8 = 64, -8·7 = -56); there is no saturation.

## Timing
- Reset values:
  - All valid/ready outputs are 0, including s_ready.
  - Address and data outputs, m_product, m_err and busy are 0; state is IDLE.
- s_ready goes to 1 in the first cycle after reset deasserts.
- Reset asserted mid-operation:
  - All outputs clear asynchronously.
  - Any in-flight transaction is abandoned and the latched operands are lost.
- Latency: with a zero-wait slave (ready in the same cycle as valid, response one cycle later) and done at the first poll:
  - Each transaction takes 2 cycles.
  - m_valid rises 10 cycles after the s handshake edge.
- Each extra poll adds 2 + POLL_GAP cycles.
- Throughput: one operation in flight; the next pair is accepted only after the OUT handshake.
- Simultaneous m handshake and new s_valid: the pair is accepted in the following cycle (IDLE), never in the same cycle.

## Configuration
- MEMRISTOR_MUL_POLL_TIMEOUT_EN:
  - Defined: a poll counter aborts to OUT with m_err = 1 and m_product = 0 after TIMEOUT_POLLS status reads without done.
  - Undefined: the counter is absent and polling continues indefinitely.

## Structure
- Package memristor_mul_pkg holds:
  - Register offset constants: REG_CTRL, REG_STAT, REG_MUL_A, REG_MUL_B, REG_RESULT.
  - RESP_OKAY.
  - The FSM state typedef.
- Sub-module axil_single_xfer:
  - A one-word AXI4-Lite read/write engine with a start/done/err handshake.
  - The top-level sequencer FSM drives it.

## Test plan
- a=3, b=7 → writes 0x3 and 0x7, then start; m_product = 0x15, m_err = 0.
- a=-3, b=5 → WDATA 32'hFFFF_FFFD at 0x08; m_product = 0xF1 (-15). Also a=-8, b=-8 → 0x40.
- Slave delays AWREADY 3 cycles while WREADY is immediate; the model reports done on the 5th poll:
  - exactly one write per register;
  - exactly 5 status reads, spaced ≥ POLL_GAP idle cycles;
  - result is correct.
- BRESP = 2'b10 on WR_B → m_err = 1, m_product = 0, no write to 0x00.
- m_ready held low 4 cycles in OUT → m_product stable, s_ready = 0; s_ready = 1 one cycle after the handshake.
- ARESETn pulsed low during RD_STAT → all valids 0 immediately; the next pair 2×3 → 0x06.
